// File: rtl/stream_credit_rx_pkg.sv
// Shared helpers for the credit-link receive buffer.
// Latency: n/a (combinational functions only).
// Backpressure: n/a.
package stream_credit_rx_pkg;

  // Advances a circular-buffer index by one and wraps it to 0 at `depth`.
  // Works for any depth, so the buffer does not need a power-of-two size.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    return (idx + 1 >= depth) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_credit_rx.sv
// Credit-link receiver: buffers credited beats and re-emits them as a valid/ready stream.
// Latency: 1 cycle from valid_i to valid_o (no fall-through); credit_o is combinational with the pop.
// Backpressure: ready_i stalls the head; the sender is throttled by credits, and a beat with no credit left is dropped and flagged.
module stream_credit_rx
  import stream_credit_rx_pkg::*;
#(
  parameter type         T          = logic,
  parameter int unsigned NumCredits = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clr_i,
  input  logic                            testmode_i,
  input  logic                            valid_i,
  input  T                                data_i,
  output logic                            credit_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output T                                data_o,
  output logic [$clog2(NumCredits+1)-1:0] usage_o,
  output logic                            overflow_o
);

  localparam int unsigned PtrW = (NumCredits > 1) ? $clog2(NumCredits) : 1;
  localparam int unsigned UsgW = $clog2(NumCredits + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [UsgW-1:0] usg_t;

  localparam usg_t UsageFull = usg_t'(NumCredits);

  if (NumCredits == 0) begin : g_bad_depth
    $error("stream_credit_rx: NumCredits must be at least 1");
  end

  ptr_t rd_q, rd_d;
  ptr_t wr_q, wr_d;
  usg_t usage_q, usage_d;
  logic ovf_q, ovf_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // Payload storage is deliberately left out of reset and clear.
  T mem_q [NumCredits];

  logic unused_testmode;
  assign unused_testmode = testmode_i;

  assign full    = (usage_q == UsageFull);
  assign valid_o = (usage_q != '0);
  // A clear cancels the pop so that no credit goes back to a sender that is being cleared too.
  assign pop     = valid_o & ready_i & ~clr_i;
  // When full, a beat is only accepted because the same-cycle pop frees its slot.
  assign push    = valid_i & ~clr_i & (~full | pop);
  assign drop    = valid_i & ~clr_i & full & ~pop;

  assign credit_o   = pop;
  assign data_o     = mem_q[rd_q];
  assign usage_o    = usage_q;
  assign overflow_o = ovf_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    usage_d = usage_q;
    ovf_d   = ovf_q | drop;
    if (pop) begin
      rd_d = ptr_t'(wrap_inc(32'(rd_q), NumCredits));
    end
    if (push) begin
      wr_d = ptr_t'(wrap_inc(32'(wr_q), NumCredits));
    end
    case ({push, pop})
      2'b10:   usage_d = usage_q + usg_t'(1);
      2'b01:   usage_d = usage_q - usg_t'(1);
      default: usage_d = usage_q;
    endcase
  end

  // Control state: async active-low reset, synchronous clear taking priority over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      usage_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      usage_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      usage_q <= usage_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload write at the write pointer on every accepted beat.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
  // Flags a sender that pushed without holding a credit.
  overflow_drop: assert property (@(posedge clk_i) disable iff (!rst_ni) !drop)
    else $warning("stream_credit_rx: beat dropped on full buffer, sender exceeded its credits");
`endif

endmodule

// File: tb/tb_stream_credit_rx.sv
module tb_stream_credit_rx;

  logic clk;
  logic rst_n;
  logic tm;

  // Instance with 4 credits (directed scenarios)
  logic       clr4, val4, rdy4;
  logic [7:0] dat4;
  logic       cred4, vo4, ovf4;
  logic [7:0] do4;
  logic [2:0] us4;

  // Instance with 3 credits (randomized traffic)
  logic       clr3, val3, rdy3;
  logic [7:0] dat3;
  logic       cred3, vo3, ovf3;
  logic [7:0] do3;
  logic [1:0] us3;

  int total;
  int passed;
  bit cmp_en;

  stream_credit_rx #(.T(logic [7:0]), .NumCredits(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr4), .testmode_i(tm),
    .valid_i(val4), .data_i(dat4), .credit_o(cred4),
    .valid_o(vo4), .ready_i(rdy4), .data_o(do4),
    .usage_o(us4), .overflow_o(ovf4)
  );

  stream_credit_rx #(.T(logic [7:0]), .NumCredits(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr3), .testmode_i(tm),
    .valid_i(val3), .data_i(dat3), .credit_o(cred3),
    .valid_o(vo3), .ready_i(rdy3), .data_o(do3),
    .usage_o(us3), .overflow_o(ovf3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each buffer is a plain queue of beats plus a sticky drop flag.
  logic [7:0] q4[$];
  logic [7:0] q3[$];
  bit m_ovf4, m_ovf3;
  bit p4, p3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete();
      q3.delete();
      m_ovf4 = 1'b0;
      m_ovf3 = 1'b0;
    end else begin
      if (clr4) begin
        q4.delete();
        m_ovf4 = 1'b0;
      end else begin
        p4 = (q4.size() != 0) && rdy4;
        if (val4 && q4.size() == 4 && !p4) m_ovf4 = 1'b1;
        if (p4) void'(q4.pop_front());
        if (val4 && q4.size() < 4) q4.push_back(dat4);
      end
      if (clr3) begin
        q3.delete();
        m_ovf3 = 1'b0;
      end else begin
        p3 = (q3.size() != 0) && rdy3;
        if (val3 && q3.size() == 3 && !p3) m_ovf3 = 1'b1;
        if (p3) void'(q3.pop_front());
        if (val3 && q3.size() < 3) q3.push_back(dat3);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("u4.valid",  vo4,  32'(q4.size() != 0));
      chk("u4.usage",  us4,  q4.size());
      chk("u4.credit", cred4, 32'((q4.size() != 0) && rdy4 && !clr4));
      chk("u4.ovf",    ovf4, 32'(m_ovf4));
      if (q4.size() != 0) chk("u4.data", do4, q4[0]);
      chk("u3.valid",  vo3,  32'(q3.size() != 0));
      chk("u3.usage",  us3,  q3.size());
      chk("u3.credit", cred3, 32'((q3.size() != 0) && rdy3 && !clr3));
      chk("u3.ovf",    ovf3, 32'(m_ovf3));
      if (q3.size() != 0) chk("u3.data", do3, q3[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp4 [4];
  int credits;
  int pushes;
  int creds;
  bit v;

  initial begin
    tm = 1'b0;
    rst_n = 1'b0;
    clr4 = 0; val4 = 0; rdy4 = 0; dat4 = '0;
    clr3 = 0; val3 = 0; rdy3 = 0; dat3 = '0;
    cmp_en = 1'b1;
    #22;
    chk("reset.valid",  vo4, 0);
    chk("reset.usage",  us4, 0);
    chk("reset.ovf",    ovf4, 0);
    chk("reset.credit", cred4, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Four beats with ready low, then drained in order.
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      val4 = 1; dat4 = exp4[i];
      cyc();
    end
    val4 = 0;
    #2;
    chk("fill.usage", us4, 4);
    chk("fill.credit", cred4, 0);
    cyc();
    rdy4 = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("drain.data", do4, exp4[i]);
      chk("drain.credit", cred4, 1);
      cyc();
    end
    rdy4 = 0;
    #2;
    chk("drain.empty", vo4, 0);
    cyc();

    // Push into empty buffer with ready held: no fall-through.
    val4 = 1; dat4 = 8'hA5; rdy4 = 1;
    #2;
    chk("nofall.valid", vo4, 0);
    chk("nofall.credit", cred4, 0);
    cyc();
    val4 = 0;
    #2;
    chk("nofall.valid1", vo4, 1);
    chk("nofall.data", do4, 8'hA5);
    chk("nofall.credit1", cred4, 1);
    cyc();
    rdy4 = 0;
    cyc();

    // Overflow on a full buffer, then clear.
    for (int i = 0; i < 4; i++) begin
      val4 = 1; dat4 = 8'(8'hC0 + i);
      cyc();
    end
    dat4 = 8'h99;
    #2;
    chk("ovf.before", ovf4, 0);
    cyc();
    val4 = 0;
    #2;
    chk("ovf.set", ovf4, 1);
    chk("ovf.usage", us4, 4);
    chk("ovf.head", do4, 8'hC0);
    cyc();
    #2;
    chk("ovf.held", ovf4, 1);
    clr4 = 1; rdy4 = 1;
    #1;
    chk("clr.credit", cred4, 0);
    cyc();
    clr4 = 0; rdy4 = 0;
    #2;
    chk("clr.ovf", ovf4, 0);
    chk("clr.usage", us4, 0);
    cyc();

    // Full buffer with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) begin
      val4 = 1; dat4 = 8'(i);
      cyc();
    end
    dat4 = 8'h55; rdy4 = 1;
    #2;
    chk("fullpp.credit", cred4, 1);
    chk("fullpp.head", do4, 8'h01);
    cyc();
    val4 = 0;
    exp4[0] = 8'h02; exp4[1] = 8'h03; exp4[2] = 8'h04; exp4[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (i == 0) begin
        chk("fullpp.usage", us4, 4);
        chk("fullpp.ovf", ovf4, 0);
      end
      chk("fullpp.data", do4, exp4[i]);
      cyc();
    end
    rdy4 = 0;
    cyc();

    // Reset with two beats buffered, then push right after release.
    val4 = 1; dat4 = 8'h61; cyc();
    dat4 = 8'h62; cyc();
    val4 = 0;
    #2;
    chk("rst.pre_usage", us4, 2);
    rst_n = 0;
    #1;
    chk("rst.valid", vo4, 0);
    chk("rst.usage", us4, 0);
    chk("rst.credit", cred4, 0);
    cyc();
    cyc();
    rst_n = 1; val4 = 1; dat4 = 8'h77;
    cyc();
    val4 = 0;
    #2;
    chk("rst.first_push", vo4, 1);
    chk("rst.first_data", do4, 8'h77);
    chk("rst.first_usage", us4, 1);
    rdy4 = 1;
    cyc();
    rdy4 = 0;
    cyc();

    // Credit-throttled random traffic on the 3-deep instance.
    credits = 3; pushes = 0; creds = 0;
    for (int i = 0; i < 10000; i++) begin
      v = (credits > 0) && ($urandom_range(0, 3) != 0);
      val3 = v;
      dat3 = 8'($urandom);
      rdy3 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      #1;
      if (v) begin credits--; pushes++; end
      if (cred3) begin credits++; creds++; end
      cyc();
    end
    val3 = 0; rdy3 = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (cred3) begin credits++; creds++; end
      cyc();
    end
    rdy3 = 0;
    chk("rand.credits_home", credits, 3);
    chk("rand.credits_eq_pushes", creds, pushes);
    chk("rand.usage_end", us3, 0);
    chk("rand.no_ovf", ovf3, 0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_credit_rx.md
STREAM_CREDIT_RX -- requirements
Module: stream_credit_rx

Interface
REQ-001 SHALL have parameter T, type, default logic: payload type.
REQ-002 SHALL have parameter NumCredits, int unsigned, default 4: receive buffer depth and initial credit count held by the sender; legal range 1..256.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear.
REQ-006 SHALL have port testmode_i  input  1  test mode; accepted, no functional effect.
REQ-007 SHALL have port valid_i  input  1  credit-link beat valid; there is no ready.
REQ-008 SHALL have port data_i  input  T  credit-link payload.
REQ-009 SHALL have port credit_o  output  1  one-cycle pulse returning one credit to the sender.
REQ-010 SHALL have port valid_o  output  1  stream valid.
REQ-011 SHALL have port ready_i  input  1  stream ready.
REQ-012 SHALL have port data_o  output  T  stream payload.
REQ-013 SHALL have port usage_o  output  $clog2(NumCredits+1)  current buffer occupancy.
REQ-014 SHALL have port overflow_o  output  1  sticky protocol-violation flag.

Function
REQ-015 The buffer SHALL be a circular FIFO of NumCredits entries with read and write pointers wrapping from NumCredits-1 to 0. Non-power-of-two depths SHALL be supported.
- push = valid_i and accepted.
- pop = valid_o & ready_i.
REQ-016 valid_o SHALL equal (usage_o != 0). data_o SHALL be the entry at the read pointer and SHALL hold stable while valid_o=1 and ready_i=0.
REQ-017 Latency SHALL be exactly 1 cycle, with no fall-through: a beat pushed in cycle N first appears on valid_o/data_o in cycle N+1.
REQ-018 credit_o SHALL equal pop, combinationally. Exactly one credit pulse SHALL be produced per popped beat.
REQ-019 When full (usage_o == NumCredits):
- push without a same-cycle pop SHALL drop the beat, leave the buffer unchanged, and set overflow_o.
- push with a same-cycle pop SHALL be accepted, with usage_o unchanged.
REQ-020 Occupancy update per cycle:
- push only: usage_o +1.
- pop only: usage_o -1.
- both: unchanged.
- usage_o SHALL never exceed NumCredits or underflow.
REQ-021 When empty, a simultaneous push and ready_i=1 SHALL NOT pop, because there is no fall-through. credit_o SHALL stay 0.
REQ-022 overflow_o SHALL remain 1 until clr_i or reset.
REQ-023 clr_i=1 SHALL take priority over push and pop in the same cycle. It SHALL empty the buffer, zero both pointers and overflow_o, and return no credits.
- The sender is required to be cleared in the same cycle.
- credit_o SHALL be forced to 0 while clr_i=1.
REQ-024 Payload storage SHALL NOT be reset or cleared; only control state is.

Reset
REQ-025 rst_ni=0 SHALL asynchronously force:
- pointers = 0;
- usage_o = 0;
- valid_o = 0;
- overflow_o = 0;
- credit_o = 0.
data_o is don't-care while valid_o=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats without credit return. After reset the sender holds NumCredits credits.
REQ-027 The first push SHALL be accepted in the first cycle after rst_ni rises.

Structure
REQ-028 Control registers SHALL use the codebase FF macros: asynchronous active-low reset with synchronous clear.
REQ-029 No shared package is required, because the block is fully parameterized by T and NumCredits. The credit-count typedef SHALL live in the existing stream common package if the sender block needs it.
REQ-030 The block SHALL be self-contained with no sub-module; storage SHALL be inline. The natural companion is a separate module, stream_credit_tx, the sending end.
REQ-031 An assertion SHALL flag NumCredits == 0 at elaboration. A simulation-only assertion SHALL fire on overflow.

Verification
REQ-032 NumCredits=4, T=logic[7:0]; push 0x11,0x22,0x33,0x44 with ready_i=0 -> usage_o=4, no credit_o. Then ready_i=1 for 4 cycles -> data_o 0x11,0x22,0x33,0x44 in order, 4 single-cycle credit_o pulses.
REQ-033 Empty buffer; push 0xA5 with ready_i=1 held -> valid_o=0 in the push cycle, valid_o=1 with data 0xA5 the next cycle, credit_o pulses that cycle.
REQ-034 Full buffer; push 0x99 with ready_i=0 -> beat dropped, usage_o stays 4, overflow_o=1 and held. Then clr_i -> overflow_o=0, usage_o=0.
REQ-035 Full buffer; push 0x55 with ready_i=1 in the same cycle -> head popped, credit_o=1, usage_o stays 4, 0x55 emerges last; overflow_o stays 0.
REQ-036 NumCredits=3; random valid_i throttled by a credit counter and random ready_i for 10k cycles -> output order equals input order, no overflow, total credit_o count equals beats popped, pointers wrap correctly.
REQ-037 rst_ni pulsed low with 2 entries buffered -> valid_o=0 and usage_o=0 immediately. A push in the first cycle after release is accepted.
